// File: rtl/sata_link_rx_frame_buffer.sv
// SATA link-layer receive frame buffer: captures one FIS, holds it for
// transport readout (FWFT), throttles the link via read_ready.
// Ports: link read_* / remote_abort in, read_ready out; transport fis_*
// readout and release; overflow, dropped_frame and state_dbg status.
module sata_link_rx_frame_buffer #(
  parameter int ADDR_WIDTH  = 11,
  parameter int HOLD_MARGIN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_start,
  input  logic                  read_strobe,
  input  logic [31:0]           read_data,
  input  logic                  read_finished,
  input  logic                  read_crc_ok,
  input  logic                  remote_abort,
  output logic                  read_ready,
  output logic                  fis_valid,
  output logic [ADDR_WIDTH:0]   fis_size,
  output logic                  fis_crc_ok,
  input  logic                  fis_rd_strobe,
  output logic [31:0]           fis_rd_data,
  output logic                  fis_rd_empty,
  input  logic                  fis_done,
  output logic                  overflow,
  output logic                  dropped_frame,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] MARGIN_C = (ADDR_WIDTH+1)'(HOLD_MARGIN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RECEIVE    = 2'd1,
    HOLD_FRAME = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;
  logic                  crc_q, crc_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic                  drop_q, drop_d;
  logic                  ready_q, ready_d;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           mem_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    crc_d    = crc_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    drop_d   = 1'b0;
    we       = 1'b0;
    waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
    unique case (state_q)
      IDLE: begin
        if (read_start) begin
          state_d  = RECEIVE;
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
          if (read_strobe) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = (ADDR_WIDTH+1)'(1);
          end
        end
      end
      RECEIVE: begin
        if (remote_abort) begin
          state_d = IDLE;
        end else if (read_start) begin
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
          if (read_strobe) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_d = (ADDR_WIDTH+1)'(1);
          end
        end else begin
          if (read_strobe) begin
            if (wr_ptr_q == DEPTH_C) begin
              ovf_d = 1'b1;
            end else begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
          // Same-cycle strobe is already folded into wr_ptr_d/ovf_d.
          if (read_finished) begin
            size_d   = wr_ptr_d;
            crc_d    = read_crc_ok & ~ovf_d;
            rd_ptr_d = '0;
            valid_d  = 1'b1;
            state_d  = HOLD_FRAME;
          end
        end
      end
      HOLD_FRAME: begin
        drop_d = read_start;
        if (fis_rd_strobe && (rd_ptr_q != size_q))
          rd_ptr_d = rd_ptr_q + 1'b1;
        if (fis_done) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready follows the next state so it lands with the pointer update.
  always_comb begin
    ready_d = 1'b0;
    unique case (state_d)
      IDLE:    ready_d = 1'b1;
      RECEIVE: ready_d = (DEPTH_C - wr_ptr_d) > MARGIN_C;
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
      crc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
      crc_q    <= crc_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem_q[waddr] <= read_data;
  end

  assign fis_rd_data   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign fis_rd_empty  = (rd_ptr_q == size_q);
  assign read_ready    = ready_q;
  assign fis_valid     = valid_q;
  assign fis_size      = size_q;
  assign fis_crc_ok    = crc_q;
  assign overflow      = ovf_q;
  assign dropped_frame = drop_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sata_link_rx_frame_buffer.sv
// Self-checking bench for sata_link_rx_frame_buffer (DEPTH=16, margin 4).
// Frame vectors table plus directed threshold/abort/drop/reset cases.
module tb_sata_link_rx_frame_buffer;

  localparam int AW = 4;
  localparam int HM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_start = 1'b0;
  logic          read_strobe = 1'b0;
  logic [31:0]   read_data = '0;
  logic          read_finished = 1'b0;
  logic          read_crc_ok = 1'b0;
  logic          remote_abort = 1'b0;
  logic          read_ready;
  logic          fis_valid;
  logic [AW:0]   fis_size;
  logic          fis_crc_ok;
  logic          fis_rd_strobe = 1'b0;
  logic [31:0]   fis_rd_data;
  logic          fis_rd_empty;
  logic          fis_done = 1'b0;
  logic          overflow;
  logic          dropped_frame;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    int len;
    bit crc;
    bit fin_last;
    int exp_size;
    bit exp_crc;
  } vec_t;
  vec_t vecs[6];

  sata_link_rx_frame_buffer #(.ADDR_WIDTH(AW), .HOLD_MARGIN(HM)) dut (
    .clk(clk), .rst(rst),
    .read_start(read_start), .read_strobe(read_strobe),
    .read_data(read_data), .read_finished(read_finished),
    .read_crc_ok(read_crc_ok), .remote_abort(remote_abort),
    .read_ready(read_ready), .fis_valid(fis_valid),
    .fis_size(fis_size), .fis_crc_ok(fis_crc_ok),
    .fis_rd_strobe(fis_rd_strobe), .fis_rd_data(fis_rd_data),
    .fis_rd_empty(fis_rd_empty), .fis_done(fis_done),
    .overflow(overflow), .dropped_frame(dropped_frame),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] d);
    read_strobe = 1'b1;
    read_data = d;
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic start();
    read_start = 1'b1;
    tick();
    read_start = 1'b0;
  endtask

  task automatic run_frame(input int len, input bit crc,
                           input bit fin_last, input logic [31:0] base);
    logic [31:0] d;
    start();
    for (int i = 0; i < len; i++) begin
      d = base + 32'((i + 1) * 17);
      sb_q.push_back(d);
      read_strobe = 1'b1;
      read_data = d;
      if (fin_last && i == len - 1) begin
        chk("valid_pre", 32'(fis_valid), 32'd0);
        read_finished = 1'b1;
        read_crc_ok = crc;
      end
      tick();
      read_strobe = 1'b0;
      read_finished = 1'b0;
    end
    if (!(fin_last && len > 0)) begin
      chk("valid_pre", 32'(fis_valid), 32'd0);
      read_finished = 1'b1;
      read_crc_ok = crc;
      tick();
      read_finished = 1'b0;
    end
  endtask

  task automatic check_held(input int sz, input bit crc);
    chk("fis_valid", 32'(fis_valid), 32'd1);
    chk("fis_size", 32'(fis_size), 32'(sz));
    chk("fis_crc_ok", 32'(fis_crc_ok), 32'(crc));
    chk("ready_hold", 32'(read_ready), 32'd0);
    chk("state_hold", 32'(state_dbg), 32'd2);
  endtask

  task automatic readout(input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = sb_q.pop_front();
      chk("rd_empty_lo", 32'(fis_rd_empty), 32'd0);
      chk("rd_data", fis_rd_data, e);
      fis_rd_strobe = 1'b1;
      tick();
      fis_rd_strobe = 1'b0;
    end
  endtask

  task automatic release_buf();
    fis_done = 1'b1;
    tick();
    fis_done = 1'b0;
    chk("valid_rel", 32'(fis_valid), 32'd0);
    chk("ready_rel", 32'(read_ready), 32'd1);
    chk("state_rel", 32'(state_dbg), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    vecs[0] = '{5, 1'b1, 1'b0, 5, 1'b1};
    vecs[1] = '{5, 1'b0, 1'b0, 5, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b0, 0, 1'b1};
    vecs[3] = '{3, 1'b1, 1'b1, 3, 1'b1};
    vecs[4] = '{1, 1'b1, 1'b1, 1, 1'b1};
    vecs[5] = '{16, 1'b1, 1'b0, 16, 1'b1};

    tick();
    tick();
    chk("rst_ready", 32'(read_ready), 32'd0);
    chk("rst_valid", 32'(fis_valid), 32'd0);
    chk("rst_size", 32'(fis_size), 32'd0);
    chk("rst_crc", 32'(fis_crc_ok), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(dropped_frame), 32'd0);
    chk("rst_empty", 32'(fis_rd_empty), 32'd1);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(read_ready), 32'd1);

    strobe(32'hbad0_0001);
    chk("idle_strobe", 32'(state_dbg), 32'd0);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].len, vecs[v].crc, vecs[v].fin_last,
                32'(v) << 8);
      check_held(vecs[v].exp_size, vecs[v].exp_crc);
      readout(vecs[v].len);
      chk("rd_empty_end", 32'(fis_rd_empty), 32'd1);
      fis_rd_strobe = 1'b1;
      tick();
      fis_rd_strobe = 1'b0;
      chk("rd_extra", 32'(fis_rd_empty), 32'd1);
      release_buf();
    end

    start();
    for (int i = 1; i <= 18; i++) begin
      if (i <= 16) sb_q.push_back(32'h1000 + 32'(i));
      strobe(32'h1000 + 32'(i));
      chk($sformatf("thr_ready_%0d", i), 32'(read_ready),
          32'(i < 12));
      if (i == 16) chk("ovf_16", 32'(overflow), 32'd0);
      if (i == 17) chk("ovf_17", 32'(overflow), 32'd1);
    end
    read_finished = 1'b1;
    read_crc_ok = 1'b1;
    tick();
    read_finished = 1'b0;
    check_held(16, 1'b0);
    chk("ovf_held", 32'(overflow), 32'd1);
    readout(16);
    chk("ovf_empty", 32'(fis_rd_empty), 32'd1);
    release_buf();

    start();
    for (int i = 0; i < 3; i++) begin
      strobe(32'hab00 + 32'(i));
      chk("abort_valid", 32'(fis_valid), 32'd0);
    end
    remote_abort = 1'b1;
    read_finished = 1'b1;
    tick();
    remote_abort = 1'b0;
    read_finished = 1'b0;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_valid2", 32'(fis_valid), 32'd0);
    run_frame(2, 1'b1, 1'b0, 32'h2000);
    check_held(2, 1'b1);
    readout(2);
    release_buf();

    run_frame(4, 1'b1, 1'b0, 32'h4000);
    check_held(4, 1'b1);
    chk("drop_pre", 32'(dropped_frame), 32'd0);
    start();
    chk("drop_pulse", 32'(dropped_frame), 32'd1);
    for (int i = 0; i < 4; i++) begin
      strobe(32'hdead_0000 + 32'(i));
      if (i == 0) chk("drop_clear", 32'(dropped_frame), 32'd0);
    end
    check_held(4, 1'b1);
    readout(2);
    release_buf();

    start();
    strobe(32'h5551);
    strobe(32'h5552);
    read_start = 1'b1;
    sb_q.push_back(32'h777);
    strobe(32'h777);
    read_start = 1'b0;
    chk("restart_ovf", 32'(overflow), 32'd0);
    sb_q.push_back(32'h888);
    strobe(32'h888);
    read_finished = 1'b1;
    read_crc_ok = 1'b1;
    tick();
    read_finished = 1'b0;
    check_held(2, 1'b1);
    readout(2);
    release_buf();

    start();
    strobe(32'h6661);
    strobe(32'h6662);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(read_ready), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_valid", 32'(fis_valid), 32'd0);
    chk("mid_rst_empty", 32'(fis_rd_empty), 32'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(read_ready), 32'd1);
    chk("post_rst_valid", 32'(fis_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sata_link_rx_frame_buffer.md
Name: sata_link_rx_frame_buffer

Overview:
- Sits directly downstream of the SATA link layer read path. Captures one received FIS payload (read_start/read_strobe/read_data/read_finished/read_crc_ok).
- Drives read_ready back to the link layer so it can throttle the far end with HOLD.
- Presents the completed frame, its dword count and its CRC status to the transport layer. The transport layer reads the frame out first-word-fall-through and releases the buffer when done.

Parameters:
- ADDR_WIDTH, 11, log2 of buffer depth in dwords (default depth 2048 dwords = 8 KB FIS max).
- HOLD_MARGIN, 8, free-dword threshold at or below which read_ready deasserts during receive.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- read_start  in  1  link layer: SOF seen, frame begins (1-cycle strobe)
- read_strobe  in  1  link layer: read_data valid this cycle
- read_data  in  32  link layer: descrambled payload dword
- read_finished  in  1  link layer: EOF processed, read_crc_ok valid (1-cycle strobe)
- read_crc_ok  in  1  link layer: CRC result, sampled on read_finished
- remote_abort  in  1  link layer: far end aborted (SYNC escape)
- read_ready  out  1  to link layer: buffer can accept dwords
- fis_valid  out  1  complete frame available to transport
- fis_size  out  ADDR_WIDTH+1  number of dwords stored
- fis_crc_ok  out  1  latched CRC status of the stored frame
- fis_rd_strobe  in  1  transport: consume current dword
- fis_rd_data  out  32  current dword (FWFT)
- fis_rd_empty  out  1  all stored dwords consumed
- fis_done  in  1  transport: release buffer (1-cycle strobe)
- overflow  out  1  sticky per frame: dword(s) dropped because buffer full
- dropped_frame  out  1  1-cycle pulse: read_start arrived while a frame was held
- state_dbg  out  2  current state

Behaviour:
- Reset: state=IDLE, wr_ptr=rd_ptr=0, read_ready=0 for the reset cycle then 1 in IDLE, fis_valid=0, fis_size=0, fis_crc_ok=0, overflow=0, dropped_frame=0, fis_rd_empty=1. Buffer RAM contents are don't-care.
- States: IDLE(0), RECEIVE(1), HOLD_FRAME(2).
- IDLE:
  - read_ready=1.
  - read_start -> RECEIVE; wr_ptr<=0; overflow<=0.
  - read_strobe in IDLE is ignored.
- RECEIVE:
  - Each read_strobe writes read_data at wr_ptr and increments wr_ptr.
  - read_start and read_strobe in the same cycle: the dword is written at address 0.
  - read_ready = (DEPTH - wr_ptr) > HOLD_MARGIN, registered. It drops one cycle after the threshold is crossed.
  - Strobe with wr_ptr == DEPTH: no write, wr_ptr holds, overflow<=1.
- read_finished in RECEIVE:
  - fis_size<=wr_ptr; fis_crc_ok<=read_crc_ok & ~overflow; rd_ptr<=0; -> HOLD_FRAME.
  - A read_strobe in the same cycle is written first and counted in fis_size.
- remote_abort in RECEIVE:
  - -> IDLE, frame discarded, fis_valid stays 0.
  - remote_abort has priority over read_finished in the same cycle.
- read_start while in RECEIVE: restart; wr_ptr<=0, overflow<=0.
- HOLD_FRAME:
  - fis_valid=1, read_ready=0.
  - fis_rd_data = RAM[rd_ptr], valid the same cycle rd_ptr changes (FWFT; use a registered read with prefetch or distributed RAM).
  - fis_rd_strobe with rd_ptr<fis_size: rd_ptr++.
  - fis_rd_strobe with rd_ptr==fis_size: ignored.
  - fis_rd_empty = (rd_ptr==fis_size).
  - fis_done -> IDLE next cycle; fis_valid<=0; read_ready<=1. fis_done is legal before all dwords are read.
  - read_start in HOLD_FRAME: dropped_frame pulses; the held frame is not corrupted; the following strobes are ignored.
- Zero-length frame (read_finished with no strobes): fis_size=0, fis_valid=1, fis_rd_empty=1.
- fis_size width is ADDR_WIDTH+1 so that a full buffer (DEPTH) is representable.
- rst mid-frame: all state returns to reset values on the next edge; a partial frame is lost.

Test Plan:
- Nominal 5-dword frame 0x11..0x55, read_crc_ok=1:
  - fis_valid=1 one cycle after read_finished; fis_size=5; fis_crc_ok=1.
  - 5 rd_strobes return 0x11..0x55, then fis_rd_empty=1.
  - fis_done -> read_ready=1 next cycle.
- Same frame with read_crc_ok=0 -> fis_crc_ok=0, data still readable, fis_size=5.
- Threshold and overflow, ADDR_WIDTH=4 (DEPTH=16), HOLD_MARGIN=4:
  - read_ready falls the cycle after the 12th strobe.
  - Continue to 18 strobes -> fis_size=16, overflow=1, fis_crc_ok=0.
- Abort: start, 3 strobes, remote_abort -> state IDLE, fis_valid never asserts. The next 2-dword frame reports fis_size=2.
- Held frame, second read_start plus 4 strobes -> dropped_frame 1-cycle pulse; held frame data and fis_size are unchanged.
- Edge cases:
  - Zero-length frame -> fis_size=0, fis_rd_empty=1.
  - read_finished coincident with the 3rd strobe -> fis_size=3.
  - rst asserted during RECEIVE -> read_ready=0 during reset, then 1; fis_valid=0.
